// File: rtl/ct_lsu_spsram_512x7_ctrl.sv
// ct_lsu_spsram_512x7_ctrl: clears a single-port SRAM after reset, then issues handshaked reads/writes as active-low macro cycles.
// Optional CT_SPSRAM_CTRL_RDATA_FLOP_EN registers read data, which adds one cycle of response latency.
`default_nettype none

module ct_lsu_spsram_512x7_ctrl #(
  parameter int                    ADDR_WIDTH = 9,
  parameter int                    DATA_WIDTH = 7,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  init_req,
  input  logic                  req_vld,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_bwe,
  output logic                  req_rdy,
  output logic                  rsp_vld,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_INIT  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  localparam logic [ADDR_WIDTH:0] CNT_LAST = {1'b0, {ADDR_WIDTH{1'b1}}};

  logic [1:0]          state_q, state_d;
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;
  logic                init_done_q, init_done_d;
  logic                rd_vld_q, rd_vld_d;
  logic                accept;

  assign req_rdy   = (state_q == ST_READY) && !init_req;
  assign accept    = req_rdy && req_vld;
  assign rd_vld_d  = accept && !req_wr;
  assign init_done = init_done_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_IDLE: begin
        state_d     = ST_INIT;
        cnt_d       = '0;
        init_done_d = 1'b0;
      end
      ST_INIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d     = ST_READY;
          cnt_d       = '0;
          init_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READY: begin
        if (init_req) begin
          state_d     = ST_INIT;
          cnt_d       = '0;
          init_done_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cnt_d       = '0;
        init_done_d = 1'b0;
      end
    endcase
  end

  // Macro pins are purely combinational so an async reset idles them at once.
  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    if (state_q == ST_INIT) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = cnt_q[ADDR_WIDTH-1:0];
      sram_d    = INIT_VALUE;
    end else if (accept) begin
      sram_cen = 1'b0;
      sram_a   = req_addr;
      if (req_wr) begin
        sram_gwen = 1'b0;
        sram_wen  = ~req_bwe;
        sram_d    = req_wdata;
      end
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      rd_vld_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      rd_vld_q    <= rd_vld_d;
    end
  end

`ifdef CT_SPSRAM_CTRL_RDATA_FLOP_EN
  logic                  rsp_vld_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rsp_vld_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_vld_q   <= rd_vld_q;
      rsp_rdata_q <= rd_vld_q ? sram_q : '0;
    end
  end

  assign rsp_vld   = rsp_vld_q;
  assign rsp_rdata = rsp_rdata_q;
`else
  assign rsp_vld   = rd_vld_q;
  assign rsp_rdata = rd_vld_q ? sram_q : '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ct_lsu_spsram_512x7_ctrl.sv
// Self-checking bench for ct_lsu_spsram_512x7_ctrl with a behavioural SRAM macro and a remaining-cycles/array/queue reference model.
`default_nettype none

module tb_ct_lsu_spsram_512x7_ctrl;

  localparam logic [6:0] INITV = 7'h00;
`ifdef CT_SPSRAM_CTRL_RDATA_FLOP_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       cpurst_b;
  logic       init_req, req_vld, req_wr;
  logic [8:0] req_addr;
  logic [6:0] req_wdata, req_bwe;
  logic       req_rdy, rsp_vld, init_done;
  logic [6:0] rsp_rdata;
  logic       sram_cen, sram_gwen;
  logic [6:0] sram_wen, sram_d, sram_q;
  logic [8:0] sram_a;

  always #5 clk = ~clk;

  ct_lsu_spsram_512x7_ctrl #(.ADDR_WIDTH(9), .DATA_WIDTH(7), .INIT_VALUE(INITV)) dut (
    .forever_cpuclk(clk), .cpurst_b(cpurst_b), .init_req(init_req),
    .req_vld(req_vld), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_bwe(req_bwe), .req_rdy(req_rdy),
    .rsp_vld(rsp_vld), .rsp_rdata(rsp_rdata), .init_done(init_done),
    .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
    .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q)
  );

  // Behavioural macro: q valid one cycle after a read edge, bit-masked writes.
  logic [6:0] mem [512];
  logic       seeded = 1'b0;
  logic [6:0] q_r = 7'h00;
  assign sram_q = q_r;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 512; i++) mem[i] <= 7'($urandom);
      seeded <= 1'b1;
    end else if (!sram_cen) begin
      if (!sram_gwen) begin
        for (int b = 0; b < 7; b++) if (!sram_wen[b]) mem[sram_a][b] <= sram_d[b];
      end else begin
        q_r <= mem[sram_a];
      end
    end
  end

  typedef struct { int due; logic [6:0] data; } rsp_t;
  rsp_t       expq[$];
  logic [6:0] ref_mem [512];
  int         sweep_left;   // 513 = idle cycle pending, 1..512 = clearing, 0 = usable
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic vld, input logic wr, input logic [8:0] a,
                     input logic [6:0] wd, input logic [6:0] be, input logic ir);
    req_vld = vld; req_wr = wr; req_addr = a; req_wdata = wd; req_bwe = be; init_req = ir;
  endtask

  task automatic step();
    logic       e_rdy, acc, e_cen, e_gwen, chk_d;
    logic [6:0] e_wen, e_d;
    logic [8:0] e_a;
    #1;
    e_rdy = (sweep_left == 0) && !init_req;
    acc   = e_rdy && req_vld;
    e_cen = 1'b1; e_gwen = 1'b1; e_wen = 7'h7F; e_a = 9'd0; e_d = 7'h00; chk_d = 1'b1;
    if (sweep_left >= 1 && sweep_left <= 512) begin
      e_cen = 1'b0; e_gwen = 1'b0; e_wen = 7'h00; e_a = 9'(512 - sweep_left); e_d = INITV;
    end else if (acc && req_wr) begin
      e_cen = 1'b0; e_gwen = 1'b0; e_wen = ~req_bwe; e_a = req_addr; e_d = req_wdata;
    end else if (acc) begin
      e_cen = 1'b0; e_a = req_addr; chk_d = 1'b0;
    end
    chk("req_rdy", 32'(req_rdy), 32'(e_rdy));
    chk("init_done", 32'(init_done), 32'(sweep_left == 0));
    chk("sram_cen", 32'(sram_cen), 32'(e_cen));
    chk("sram_gwen", 32'(sram_gwen), 32'(e_gwen));
    chk("sram_wen", 32'(sram_wen), 32'(e_wen));
    chk("sram_a", 32'(sram_a), 32'(e_a));
    if (chk_d) chk("sram_d", 32'(sram_d), 32'(e_d));
    @(posedge clk);
    if (acc) begin
      if (req_wr) ref_mem[req_addr] = (ref_mem[req_addr] & ~req_bwe) | (req_wdata & req_bwe);
      else expq.push_back('{cyc + LAT, ref_mem[req_addr]});
    end
    if (sweep_left > 0) sweep_left--;
    else if (init_req) begin
      sweep_left = 512;
      for (int i = 0; i < 512; i++) ref_mem[i] = INITV;
    end
    cyc++;
    @(negedge clk);
    if (expq.size() > 0 && expq[0].due == cyc) begin
      chk("rsp_vld", 32'(rsp_vld), 32'd1);
      chk("rsp_rdata", 32'(rsp_rdata), 32'(expq[0].data));
      void'(expq.pop_front());
    end else begin
      chk("rsp_vld_idle", 32'(rsp_vld), 32'd0);
      chk("rsp_rdata_idle", 32'(rsp_rdata), 32'd0);
    end
  endtask

  task automatic do_reset();
    cpurst_b = 1'b0;
    drv(1'b0, 1'b0, 9'd0, 7'h00, 7'h00, 1'b0);
    #1;
    chk("rst_cen", 32'(sram_cen), 32'd1);
    chk("rst_gwen", 32'(sram_gwen), 32'd1);
    chk("rst_wen", 32'(sram_wen), 32'h7F);
    chk("rst_a", 32'(sram_a), 32'd0);
    chk("rst_d", 32'(sram_d), 32'd0);
    chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_req_rdy", 32'(req_rdy), 32'd0);
    expq.delete();
    sweep_left = 513;
    for (int i = 0; i < 512; i++) ref_mem[i] = INITV;
    @(negedge clk);
    @(negedge clk);
    cpurst_b = 1'b1;
  endtask

  task automatic run_sweep();
    while (sweep_left > 0) begin
      drv(1'b1, 1'($urandom), 9'($urandom), 7'($urandom), 7'($urandom), 1'($urandom));
      step();
    end
  endtask

  initial begin
    cpurst_b = 1'b0;
    drv(1'b0, 1'b0, 9'd0, 7'h00, 7'h00, 1'b0);
    do_reset();

    // Reset during the clear sweep at counter 200, then a full clean sweep.
    while (sweep_left != 312) begin
      drv(1'b1, 1'b0, 9'd0, 7'h00, 7'h00, 1'b0);
      step();
    end
    do_reset();
    run_sweep();

    drv(1'b1, 1'b0, 9'd0,   7'h00, 7'h00, 1'b0); step();
    drv(1'b1, 1'b0, 9'd255, 7'h00, 7'h00, 1'b0); step();
    drv(1'b1, 1'b0, 9'd511, 7'h00, 7'h00, 1'b0); step();
    drv(1'b1, 1'b1, 9'h0A5, 7'h5A, 7'h7F, 1'b0); step();
    drv(1'b1, 1'b0, 9'h0A5, 7'h00, 7'h00, 1'b0); step();
    drv(1'b1, 1'b1, 9'h033, 7'h7F, 7'h7F, 1'b0); step();
    drv(1'b1, 1'b1, 9'h033, 7'h00, 7'h0F, 1'b0); step();
    drv(1'b1, 1'b0, 9'h033, 7'h00, 7'h00, 1'b0); step();
    drv(1'b1, 1'b1, 9'd1,   7'h11, 7'h7F, 1'b0); step();
    drv(1'b1, 1'b1, 9'd2,   7'h22, 7'h7F, 1'b0); step();
    drv(1'b1, 1'b1, 9'd3,   7'h33, 7'h7F, 1'b0); step();
    drv(1'b1, 1'b0, 9'd1,   7'h00, 7'h00, 1'b0); step();
    drv(1'b1, 1'b0, 9'd2,   7'h00, 7'h00, 1'b0); step();
    drv(1'b1, 1'b0, 9'd3,   7'h00, 7'h00, 1'b0); step();
    drv(1'b0, 1'b0, 9'd0,   7'h00, 7'h00, 1'b0); step();
    drv(1'b0, 1'b0, 9'd0,   7'h00, 7'h00, 1'b0); step();

    // Read accepted just before init_req: its response must survive the restart.
    drv(1'b1, 1'b0, 9'h0A5, 7'h00, 7'h00, 1'b0); step();
    drv(1'b1, 1'b0, 9'h0A5, 7'h00, 7'h00, 1'b1); step();
    run_sweep();
    drv(1'b1, 1'b0, 9'h0A5, 7'h00, 7'h00, 1'b0); step();
    drv(1'b1, 1'b0, 9'd2,   7'h00, 7'h00, 1'b0); step();
    drv(1'b0, 1'b0, 9'd0,   7'h00, 7'h00, 1'b0); step();
    drv(1'b0, 1'b0, 9'd0,   7'h00, 7'h00, 1'b0); step();

    // Randomized traffic over a small address window to exercise read-after-write.
    for (int n = 0; n < 400; n++) begin
      drv(($urandom_range(0, 3) != 0), 1'($urandom), 9'($urandom_range(0, 7)),
          7'($urandom), 7'($urandom), ($urandom_range(0, 299) == 0));
      step();
    end
    run_sweep();

    // Reset while a read is in flight drops the response.
    drv(1'b1, 1'b0, 9'd1, 7'h00, 7'h00, 1'b0);
    #1;
    @(posedge clk);
    #1;
    do_reset();
    drv(1'b0, 1'b0, 9'd0, 7'h00, 7'h00, 1'b0); step();
    drv(1'b0, 1'b0, 9'd0, 7'h00, 7'h00, 1'b0); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
